scan_sequencer_3bit: RTL and testbench

Registered sequencer that sits directly upstream of the 3-to-8 decoder and drives its `A`, `B`, `C` and `EN` inputs. It steps a 3-bit select through all eight codes, up or down, and holds each code for a programmable dwell. Between codes it inserts one blanking cycle with `EN` low, so the decoder never shows two active outputs across a transition. It runs either one-shot or continuously and reports status through `busy`, `done` and `wrap`.

---
 rtl/scan_sequencer_3bit_pkg.sv | 39 +++
 rtl/scan_sequencer_3bit_if.sv | 37 +++
 rtl/scan_sequencer_3bit_dwell_counter.sv | 39 +++
 rtl/scan_sequencer_3bit.sv | 137 +++++++++++++
 tb/tb_scan_sequencer_3bit.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/scan_sequencer_3bit_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : scan_pkg
//  Purpose  : Shared definitions for the 3-bit scan sequencer: FSM state
//             encoding, direction/mode constants and index helpers.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACTIVE = 2'b01,
    ST_BLANK  = 2'b10
  } scan_state_t;

  localparam logic DIR_UP       = 1'b0;
  localparam logic DIR_DOWN     = 1'b1;
  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_CONT    = 1'b1;

  localparam logic [2:0] C_CODE_FIRST_UP   = 3'd0;
  localparam logic [2:0] C_CODE_FIRST_DOWN = 3'd7;

  // Next index in scan order. The 3-bit arithmetic wraps modulo 8, which
  // gives the continuous-mode wrap (7->0 up, 0->7 down) for free.
  function automatic logic [2:0] step_index(input logic [2:0] idx,
                                            input logic       dir);
    return (dir == DIR_DOWN) ? (idx - 3'd1) : (idx + 3'd1);
  endfunction

  // Terminal code is the last one visited in the current direction.
  function automatic logic is_terminal(input logic [2:0] idx,
                                       input logic       dir);
    return (dir == DIR_DOWN) ? (idx == 3'd0) : (idx == 3'd7);
  endfunction

endpackage
`default_nettype wire

// File: rtl/scan_sequencer_3bit_if.sv
`default_nettype none
// ============================================================================
//  Module   : scan_sequencer_3bit_if
//  Purpose  : Control/status bundle between a controller and the scan
//             sequencer.
//  Ports    : start, stop, mode, dir, dwell  (controller -> sequencer)
//             A, B, C, EN                    (sequencer -> decoder)
//             busy, done, wrap               (sequencer status)
//  Revision : 1.0  initial release
// ============================================================================
interface scan_sequencer_3bit_if #(
  parameter int DWELL_W = 4
);
  logic               start;
  logic               stop;
  logic               mode;
  logic               dir;
  logic [DWELL_W-1:0] dwell;
  logic               A;
  logic               B;
  logic               C;
  logic               EN;
  logic               busy;
  logic               done;
  logic               wrap;

  modport master (
    output start, stop, mode, dir, dwell,
    input  A, B, C, EN, busy, done, wrap
  );

  modport slave (
    input  start, stop, mode, dir, dwell,
    output A, B, C, EN, busy, done, wrap
  );
endinterface
`default_nettype wire

// File: rtl/scan_sequencer_3bit_dwell_counter.sv
`default_nettype none
// ============================================================================
//  Module   : dwell_counter
//  Purpose  : Counts cycles spent on the current code and flags when the
//             count reaches the latched dwell value.
//  Ports    : clk, reset    clock / synchronous active-high reset
//             clr           synchronous clear (priority over inc)
//             inc           advance the count by one
//             limit         latched dwell value to compare against
//             match         count == limit
//  Revision : 1.0  initial release
// ============================================================================
module dwell_counter #(
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  input  logic               inc,
  input  logic [DWELL_W-1:0] limit,
  output logic               match
);

  logic [DWELL_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign match = (r_count == limit);

endmodule
`default_nettype wire

// File: rtl/scan_sequencer_3bit.sv
`default_nettype none
// ============================================================================
//  Module   : scan_sequencer_3bit
//  Purpose  : Steps a 3-bit decoder select through all eight codes (up or
//             down), holding each for dwell+1 cycles followed by one blanking
//             cycle with EN low. One-shot or continuous operation.
//  Ports    : clk, reset    clock / synchronous active-high reset
//             bus (slave)   start/stop/mode/dir/dwell in,
//                           A/B/C/EN/busy/done/wrap out (all registered)
//  Revision : 1.0  initial release
// ============================================================================
module scan_sequencer_3bit
  import scan_pkg::*;
#(
  parameter int DWELL_W = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  scan_sequencer_3bit_if.slave bus
);

  scan_state_t        r_state;
  logic [2:0]         r_index;
  logic               r_en;
  logic               r_busy;
  logic               r_done;
  logic               r_wrap;
  logic               r_mode;
  logic               r_dir;
  logic [DWELL_W-1:0] r_dwell;

  logic               w_match;
  logic               w_clr;
  logic               w_inc;

  // Counter sits at zero outside ACTIVE so each code starts a fresh dwell;
  // it stops advancing on the match cycle so a full-scale dwell never wraps.
  assign w_clr = (r_state != ST_ACTIVE);
  assign w_inc = (r_state == ST_ACTIVE) && !w_match;

  dwell_counter #(
    .DWELL_W (DWELL_W)
  ) u_dwell_counter (
    .clk   (clk),
    .reset (reset),
    .clr   (w_clr),
    .inc   (w_inc),
    .limit (r_dwell),
    .match (w_match)
  );

  // Outputs are computed from the next state, so EN/busy/done/wrap line up
  // with the state they describe in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_index <= 3'd0;
      r_en    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_wrap  <= 1'b0;
      r_mode  <= MODE_ONESHOT;
      r_dir   <= DIR_UP;
      r_dwell <= '0;
    end else begin
      r_done <= 1'b0;
      r_wrap <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_en   <= 1'b0;
          r_busy <= 1'b0;
          if (bus.start && !bus.stop) begin
            r_mode  <= bus.mode;
            r_dir   <= bus.dir;
            r_dwell <= bus.dwell;
            r_index <= (bus.dir == DIR_DOWN) ? C_CODE_FIRST_DOWN
                                             : C_CODE_FIRST_UP;
            r_state <= ST_ACTIVE;
            r_en    <= 1'b1;
            r_busy  <= 1'b1;
          end
        end

        ST_ACTIVE: begin
          if (bus.stop) begin
            r_state <= ST_IDLE;
            r_en    <= 1'b0;
            r_busy  <= 1'b0;
          end else if (w_match) begin
            r_state <= ST_BLANK;
            r_en    <= 1'b0;
          end
        end

        ST_BLANK: begin
          if (bus.stop) begin
            r_state <= ST_IDLE;
            r_en    <= 1'b0;
            r_busy  <= 1'b0;
          end else if (!is_terminal(r_index, r_dir)) begin
            r_index <= step_index(r_index, r_dir);
            r_state <= ST_ACTIVE;
            r_en    <= 1'b1;
          end else if (r_mode == MODE_CONT) begin
            r_index <= step_index(r_index, r_dir);
            r_state <= ST_ACTIVE;
            r_en    <= 1'b1;
            r_wrap  <= 1'b1;
          end else begin
            // One-shot complete: index stays on the terminal code.
            r_state <= ST_IDLE;
            r_en    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_wrap  <= 1'b1;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_en    <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.A    = r_index[2];
  assign bus.B    = r_index[1];
  assign bus.C    = r_index[0];
  assign bus.EN   = r_en;
  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.wrap = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_scan_sequencer_3bit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_scan_sequencer_3bit
//  Purpose  : Directed self-checking bench for scan_sequencer_3bit.
//  Revision : 1.0  initial release
// ============================================================================
module tb_scan_sequencer_3bit;

  localparam int DWELL_W = 4;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;

  scan_sequencer_3bit_if #(.DWELL_W(DWELL_W)) bus ();

  scan_sequencer_3bit #(
    .DWELL_W (DWELL_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Advance one cycle; outputs are then sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int abc();
    return int'({bus.A, bus.B, bus.C});
  endfunction

  task automatic do_start(input logic m, input logic d, input int dw);
    bus.mode  = m;
    bus.dir   = d;
    bus.dwell = DWELL_W'(dw);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.mode  = 1'b0;
    bus.dir   = 1'b0;
    bus.dwell = '0;
  endtask

  task automatic check_idle(input string tag, input int code);
    check({tag, "_en"},   bus.EN,   0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_done"}, bus.done, 0);
    check({tag, "_wrap"}, bus.wrap, 0);
    check({tag, "_abc"},  abc(),    code);
  endtask

  // Full one-shot scan with every cycle checked against the expected code.
  task automatic run_oneshot(input logic d, input int dw);
    int code;
    do_start(1'b0, d, dw);
    code = 0;
    for (int k = 0; k < 8; k++) begin
      code = d ? (7 - k) : k;
      for (int j = 0; j <= dw; j++) begin
        check("act_en",   bus.EN,   1);
        check("act_abc",  abc(),    code);
        check("act_busy", bus.busy, 1);
        check("act_done", bus.done, 0);
        check("act_wrap", bus.wrap, 0);
        tick();
      end
      check("blank_en",   bus.EN,   0);
      check("blank_abc",  abc(),    code);
      check("blank_busy", bus.busy, 1);
      tick();
    end
    check("end_done", bus.done, 1);
    check("end_wrap", bus.wrap, 1);
    check("end_busy", bus.busy, 0);
    check("end_en",   bus.EN,   0);
    check("end_abc",  abc(),    code);
    tick();
    check_idle("post_end", code);
  endtask

  initial begin
    int wraps;
    int cyc;
    n_checks  = 0;
    n_pass    = 0;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    bus.mode  = 1'b0;
    bus.dir   = 1'b0;
    bus.dwell = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check_idle("por", 0);

    // One-shot up dwell=0: done lands at t+17.
    run_oneshot(1'b0, 0);
    // One-shot down dwell=2: done lands at t+33.
    run_oneshot(1'b1, 2);
    // Full-scale dwell must not overflow.
    run_oneshot(1'b0, 15);

    // Continuous up dwell=1, three full laps.
    wraps = 0;
    do_start(1'b1, 1'b0, 1);
    for (int lap = 0; lap < 3; lap++) begin
      for (int k = 0; k < 8; k++) begin
        for (int j = 0; j < 2; j++) begin
          check("cont_en",   bus.EN,   1);
          check("cont_abc",  abc(),    k);
          check("cont_done", bus.done, 0);
          check("cont_wrap", bus.wrap, (lap > 0 && k == 0 && j == 0) ? 1 : 0);
          if (bus.wrap) wraps++;
          tick();
        end
        check("cont_blank_en",   bus.EN,   0);
        check("cont_blank_wrap", bus.wrap, 0);
        tick();
      end
    end
    check("cont_lap4_en",   bus.EN,   1);
    check("cont_lap4_abc",  abc(),    0);
    check("cont_lap4_wrap", bus.wrap, 1);
    check("cont_lap4_done", bus.done, 0);
    if (bus.wrap) wraps++;
    check("cont_wrap_count", wraps, 3);
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    check_idle("cont_stop", 0);

    // Abort during code 3 (dwell=3: slot is 5 cycles, code 3 starts at t+16).
    do_start(1'b0, 1'b0, 3);
    repeat (15) tick();
    check("abort_pre_en",  bus.EN, 1);
    check("abort_pre_abc", abc(),  3);
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    check_idle("abort", 3);
    repeat (40) tick();
    check_idle("abort_later", 3);
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    check_idle("start_stop", 3);
    tick();
    check_idle("start_stop2", 3);

    // Start while busy is ignored: up dwell=1 one-shot finishes at t+25.
    do_start(1'b0, 1'b0, 1);
    cyc = 1;
    repeat (4) begin tick(); cyc++; end
    bus.start = 1'b1;
    bus.dir   = 1'b1;
    bus.mode  = 1'b1;
    bus.dwell = '0;
    tick(); cyc++;
    bus.start = 1'b0;
    bus.dir   = 1'b0;
    bus.mode  = 1'b0;
    tick(); cyc++;
    check("ign_c7_en",  bus.EN, 1);
    check("ign_c7_abc", abc(),  2);
    while (!bus.done && cyc < 200) begin tick(); cyc++; end
    check("ign_done_cycle", cyc, 25);
    check("ign_done_abc",   abc(), 7);
    check("ign_done_busy",  bus.busy, 0);

    // Reset mid-scan while ACTIVE on code 5 (dwell=7: slot 9, code 5 at t+46).
    do_start(1'b0, 1'b0, 7);
    repeat (45) tick();
    check("rst_pre_en",  bus.EN, 1);
    check("rst_pre_abc", abc(),  5);
    reset = 1'b1;
    tick();
    check_idle("rst_mid", 0);
    repeat (2) tick();
    reset = 1'b0;
    tick();
    check_idle("rst_after", 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
